// File: rtl/tl_main_pkg.sv
// Main-crossbar shared definitions: host-arbiter state encoding and the
// grant-index width, sized for the largest supported host count.
package tl_main_pkg;

    localparam int unsigned ArbMaxHosts = 8;
    localparam int unsigned ArbGntIdxW  = $clog2(ArbMaxHosts);

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by every TileLink-attached block.
// tl_h2d_t : host-to-device A-channel request plus D-channel ready.
// tl_d2h_t : device-to-host D-channel response plus A-channel ready.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_idx_fifo.sv
// Synchronous FIFO holding the grant index of every outstanding transaction,
// so D-channel responses can be steered back in issue order.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write wdata_i (ignored when full)
//   wdata_i      : grant index to store
//   pop_i        : drop the head entry (ignored when empty)
//   rdata_o      : head entry
//   full_o       : count == Depth
//   empty_o      : count == 0
//   count_o      : number of stored entries
module tlul_arb_idx_fifo #(
    parameter int unsigned Width = 3,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned CntW = $clog2(Depth) + 1;
    // A depth-1 FIFO still needs a one-bit pointer that simply stays at 0.
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tlul_host_arbiter.sv
// Shares one TL-UL device port between M hosts. The A channel is granted
// round-robin and held until its handshake; D responses return to the issuing
// host through an in-order FIFO of grant indices, which also bounds the number
// of outstanding transactions to MAX_OUT.
// Optional build macro TLUL_ARB_PRIO_EN: host 0 gets fixed top priority and
// hosts 1..M-1 are served round-robin among themselves.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   tl_h_i       : M host requests
//   tl_h_o       : M host responses and a_ready
//   tl_d_o       : device request
//   tl_d_i       : device response and a_ready
//   busy_o       : any transaction outstanding
module tlul_host_arbiter
    import tlul_pkg::*;
    import tl_main_pkg::*;
#(
    parameter int unsigned M       = 3,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i [M],
    output tl_d2h_t tl_h_o [M],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    output logic    busy_o
);

    arb_state_e              state_q;
    logic [ArbGntIdxW-1:0]   gnt_idx_q;
    logic [ArbGntIdxW-1:0]   rr_ptr_q;

    logic [M-1:0]            req;
    logic [M-1:0]            req_rr;
    logic [ArbGntIdxW:0]     pick;
    logic                    cur_valid;
    logic [ArbGntIdxW-1:0]   cur_idx;
    tl_h2d_t                 sel_h2d;
    logic                    head_d_ready;
    logic                    a_hs;
    logic                    d_hs;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ArbGntIdxW-1:0]   fifo_head;
    logic [$clog2(MAX_OUT):0] fifo_count;

    // Returns {found, idx}: first requester at or after ptr, modulo M.
    function automatic logic [ArbGntIdxW:0] rr_pick(input logic [M-1:0]          r,
                                                    input logic [ArbGntIdxW-1:0] ptr);
        logic [ArbGntIdxW:0] res;
        int                  idx;
        res = '0;
        for (int i = 0; i < int'(M); i++) begin
            idx = (int'(ptr) + i) % int'(M);
            if (!res[ArbGntIdxW] && r[idx]) begin
                res = {1'b1, ArbGntIdxW'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < int'(M); i++) begin
            req[i] = tl_h_i[i].a_valid;
        end
        req_rr    = req;
`ifdef TLUL_ARB_PRIO_EN
        req_rr[0] = 1'b0;
        if (req[0]) begin
            pick = {1'b1, {ArbGntIdxW{1'b0}}};
        end else begin
            pick = rr_pick(req_rr, rr_ptr_q);
        end
`else
        pick = rr_pick(req_rr, rr_ptr_q);
`endif

        // A held grant bypasses arbitration; a fresh pick passes through this cycle.
        if (state_q == ARB_GRANT) begin
            cur_valid = !fifo_full;
            cur_idx   = gnt_idx_q;
        end else begin
            cur_valid = pick[ArbGntIdxW] && !fifo_full;
            cur_idx   = pick[ArbGntIdxW-1:0];
        end

        sel_h2d      = '0;
        head_d_ready = 1'b0;
        for (int i = 0; i < int'(M); i++) begin
            if (cur_idx == ArbGntIdxW'(i)) begin
                sel_h2d = tl_h_i[i];
            end
            if (fifo_head == ArbGntIdxW'(i)) begin
                head_d_ready = tl_h_i[i].d_ready;
            end
        end

        a_hs = cur_valid && sel_h2d.a_valid && tl_d_i.a_ready;
        d_hs = !fifo_empty && tl_d_i.d_valid && head_d_ready;

        tl_d_o = '0;
        if (cur_valid) begin
            tl_d_o = sel_h2d;
        end
        // With nothing outstanding, any response beat is spurious and is absorbed.
        tl_d_o.d_ready = fifo_empty ? 1'b1 : head_d_ready;

        for (int i = 0; i < int'(M); i++) begin
            tl_h_o[i] = '0;
            if (!fifo_empty && fifo_head == ArbGntIdxW'(i)) begin
                tl_h_o[i]         = tl_d_i;
                tl_h_o[i].a_ready = 1'b0;
            end
            if (cur_valid && cur_idx == ArbGntIdxW'(i)) begin
                tl_h_o[i].a_ready = tl_d_i.a_ready;
            end
        end

        // Outputs are combinational, so hold them quiet while reset is asserted.
        if (rst_i) begin
            tl_d_o = '0;
            for (int i = 0; i < int'(M); i++) begin
                tl_h_o[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (cur_valid && !a_hs) begin
                        state_q   <= ARB_GRANT;
                        gnt_idx_q <= cur_idx;
                    end
                end
                ARB_GRANT: begin
                    if (a_hs) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
            if (a_hs) begin
                rr_ptr_q <= (cur_idx == ArbGntIdxW'(M - 1)) ? '0 : cur_idx + 1'b1;
            end
        end
    end

    tlul_arb_idx_fifo #(
        .Width (ArbGntIdxW),
        .Depth (MAX_OUT)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (a_hs),
        .wdata_i (cur_idx),
        .pop_i   (d_hs),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy_o = (fifo_count != '0);

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter (M=3, MAX_OUT=4).
module tb_tlul_host_arbiter;
    import tlul_pkg::*;

    localparam int unsigned M      = 3;
    localparam int unsigned MaxOut = 4;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t tl_h_i [M];
    tl_d2h_t tl_h_o [M];
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;
    logic    busy;

    int n_checks = 0;
    int n_errors = 0;

    tlul_host_arbiter #(
        .M       (M),
        .MAX_OUT (MaxOut)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_h_i (tl_h_i),
        .tl_h_o (tl_h_o),
        .tl_d_o (tl_d_o),
        .tl_d_i (tl_d_i),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int h);
        return 32'h4000_0000 + 32'(h) * 32'h100;
    endfunction

    function automatic logic [M-1:0] dvec();
        logic [M-1:0] v;
        for (int i = 0; i < int'(M); i++) v[i] = tl_h_o[i].d_valid;
        return v;
    endfunction

    function automatic logic [M-1:0] avec();
        logic [M-1:0] v;
        for (int i = 0; i < int'(M); i++) v[i] = tl_h_o[i].a_ready;
        return v;
    endfunction

    task automatic set_hosts(input logic [M-1:0] v);
        for (int i = 0; i < int'(M); i++) tl_h_i[i].a_valid = v[i];
    endtask

    task automatic dev_d(input logic v, input logic [31:0] data);
        tl_d_i.d_valid = v;
        tl_d_i.d_data  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_h[4];
        rst    = 1'b1;
        tl_d_i = '0;
        for (int i = 0; i < int'(M); i++) begin
            tl_h_i[i]           = '0;
            tl_h_i[i].a_address = addr_of(i);
            tl_h_i[i].a_source  = 8'(i);
            tl_h_i[i].d_ready   = 1'b1;
        end
        // Drive activity during reset: outputs must stay quiet.
        set_hosts(3'b111);
        dev_d(1'b1, 32'hdead);
        step();
        check("rst_a_valid", 32'(tl_d_o.a_valid), 32'd0);
        check("rst_d_ready", 32'(tl_d_o.d_ready), 32'd0);
        check("rst_a_ready", 32'(avec()), 32'd0);
        check("rst_d_valid", 32'(dvec()), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        set_hosts(3'b000);
        dev_d(1'b0, 32'h0);

`ifndef TLUL_ARB_PRIO_EN
        // 1: all hosts requesting, device always ready, responses one cycle later.
        set_hosts(3'b111);
        tl_d_i.a_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) set_hosts(3'b000);
            if (c > 0) dev_d(1'b1, 32'(c - 1));
            else       dev_d(1'b0, 32'h0);
            #1;
            if (c < 6) begin
                check("t1_gnt_addr", tl_d_o.a_address, addr_of(c % 3));
                check("t1_a_ready", 32'(avec()), 32'(1 << (c % 3)));
            end
            if (c > 0) begin
                check("t1_d_route", 32'(dvec()), 32'(1 << ((c - 1) % 3)));
                check("t1_d_data", tl_h_o[(c - 1) % 3].d_data, 32'(c - 1));
            end
            step();
        end

        // 2: host 1 stalled by the device; host 0 arrives mid-stall.
        dev_d(1'b0, 32'h0);
        tl_d_i.a_ready = 1'b0;
        set_hosts(3'b010);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_hosts(3'b011);
            #1;
            check("t2_hold_addr", tl_d_o.a_address, addr_of(1));
            check("t2_h0_a_ready", 32'(tl_h_o[0].a_ready), 32'd0);
            step();
        end
        tl_d_i.a_ready = 1'b1;
        #1;
        check("t2_hs_addr", tl_d_o.a_address, addr_of(1));
        check("t2_h1_a_ready", 32'(tl_h_o[1].a_ready), 32'd1);
        step();
        set_hosts(3'b001);
        #1;
        check("t2_next_addr", tl_d_o.a_address, addr_of(0));
        step();
        set_hosts(3'b000);
        dev_d(1'b1, 32'h11);
        #1;
        check("t2_rsp1_route", 32'(dvec()), 32'b010);
        step();
        dev_d(1'b1, 32'h22);
        #1;
        check("t2_rsp0_route", 32'(dvec()), 32'b001);
        check("t2_rsp0_data", tl_h_o[0].d_data, 32'h22);
        step();

        // 3: fill to MAX_OUT with no responses; then one pop admits one grant.
        dev_d(1'b0, 32'h0);
        set_hosts(3'b111);
        exp_h = '{1, 2, 0, 1};
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t3_fill_addr", tl_d_o.a_address, addr_of(exp_h[c]));
            step();
        end
        #1;
        check("t3_full_a_valid", 32'(tl_d_o.a_valid), 32'd0);
        check("t3_full_a_ready", 32'(avec()), 32'd0);
        check("t3_full_busy", 32'(busy), 32'd1);
        step();
        dev_d(1'b1, 32'h30);
        #1;
        check("t3_pop_a_valid", 32'(tl_d_o.a_valid), 32'd0);
        check("t3_pop_route", 32'(dvec()), 32'b010);
        step();
        dev_d(1'b0, 32'h0);
        #1;
        check("t3_regrant_valid", 32'(tl_d_o.a_valid), 32'd1);
        check("t3_regrant_addr", tl_d_o.a_address, addr_of(2));
        step();
        set_hosts(3'b000);
        #1;
        check("t3_refull_a_valid", 32'(tl_d_o.a_valid), 32'd0);
        exp_h = '{2, 0, 1, 2};
        for (int k = 0; k < 4; k++) begin
            dev_d(1'b1, 32'(k));
            #1;
            check("t3_drain_route", 32'(dvec()), 32'(1 << exp_h[k]));
            step();
        end
        dev_d(1'b0, 32'h0);
        #1;
        check("t3_drained_busy", 32'(busy), 32'd0);

        // 4: spurious response with nothing outstanding.
        for (int i = 0; i < int'(M); i++) tl_h_i[i].d_ready = 1'b0;
        dev_d(1'b1, 32'h44);
        #1;
        check("t4_d_ready", 32'(tl_d_o.d_ready), 32'd1);
        check("t4_d_valid", 32'(dvec()), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        step();
        check("t4_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < int'(M); i++) tl_h_i[i].d_ready = 1'b1;
        dev_d(1'b0, 32'h0);

        // 5: reset mid-transfer with two outstanding and host 2 held.
        set_hosts(3'b011);
        step();
        step();
        set_hosts(3'b100);
        tl_d_i.a_ready = 1'b0;
        #1;
        check("t5_pre_busy", 32'(busy), 32'd1);
        check("t5_pre_addr", tl_d_o.a_address, addr_of(2));
        step();
        #3;
        rst = 1'b1;
        dev_d(1'b1, 32'h55);
        #1;
        check("t5_rst_a_valid", 32'(tl_d_o.a_valid), 32'd0);
        check("t5_rst_d_ready", 32'(tl_d_o.d_ready), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_d_valid", 32'(dvec()), 32'd0);
        check("t5_rst_a_ready", 32'(avec()), 32'd0);
        step();
        rst = 1'b0;
        dev_d(1'b0, 32'h0);
        set_hosts(3'b111);
        tl_d_i.a_ready = 1'b1;
        #1;
        check("t5_first_grant", tl_d_o.a_address, addr_of(0));
        step();
        set_hosts(3'b000);
`else
        // 6: host 0 has fixed priority; the rest rotate.
        tl_d_i.a_ready = 1'b1;
        dev_d(1'b1, 32'h66);
        set_hosts(3'b101);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t6_prio_addr", tl_d_o.a_address, addr_of(0));
            step();
        end
        set_hosts(3'b110);
        exp_h = '{1, 2, 1, 2};
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t6_rr_addr", tl_d_o.a_address, addr_of(exp_h[c]));
            step();
        end
        set_hosts(3'b000);
        step();
        dev_d(1'b0, 32'h0);
        #1;
        check("t6_busy", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tlul_host_arbiter.md
Name: tlul_host_arbiter

Overview:
- Shares one TL-UL device port between M hosts. It is the arbitration stage placed in front of a shared device (ICCM, DCCM, FLASH_CTRL, timers, PLIC, peripheral crossbar) in the main crossbar.
- Grants the A channel round-robin and holds the grant until the handshake completes.
- Returns each D-channel response to the issuing host using an in-order grant-index FIFO.
- Bounds the number of outstanding transactions.

Parameters:
M, 3, number of host ports (2..8).
MAX_OUT, 4, maximum outstanding A-channel transactions; sets routing FIFO depth (power of two, 1..16).

Ports:
clk_i  input  1  clock.
rst_i  input  1  asynchronous reset, active-high.
tl_h_i  input  M x tl_h2d_t  host-side requests.
tl_h_o  output  M x tl_d2h_t  host-side responses and a_ready.
tl_d_o  output  tl_h2d_t  device-side request.
tl_d_i  input  tl_d2h_t  device-side response and a_ready.
busy_o  output  1  high while any transaction is outstanding.

Behaviour:
- Reset: all grant, pointer, FIFO and counter state is cleared.
  - tl_d_o.a_valid=0 and tl_d_o.d_ready=0.
  - Every tl_h_o a_valid-independent field is 0, including a_ready=0 and d_valid=0. busy_o=0.
  - Round-robin pointer resets so that host 0 has top priority.
- Arbiter FSM, two states:
  - IDLE: with FIFO not full, select the first requesting host (a_valid=1) searching from rr_ptr upward, modulo M. Latch its index as gnt_idx and go to GRANT in the same cycle. The A channel passes combinationally, so zero added latency.
  - GRANT: tl_d_o A fields = tl_h_i[gnt_idx] A fields. tl_h_o[gnt_idx].a_ready = tl_d_i.a_ready. Every other host sees a_ready=0.
  - The grant is held until a_valid && a_ready on the device side. Hosts may not withdraw a_valid (TL-UL rule), so no grant switch is ever allowed mid-request.
  - On handshake: push gnt_idx into the FIFO and set rr_ptr = gnt_idx+1 modulo M.
  - Next state is IDLE, and re-arbitration happens in the same cycle. Back-to-back throughput is one transaction per cycle.
- FIFO full (count==MAX_OUT): tl_d_o.a_valid is forced to 0 and every host's a_ready is 0. Arbitration is frozen until a D handshake pops an entry.
- Response routing:
  - When the FIFO is non-empty, head=h. tl_h_o[h] D fields = tl_d_i D fields and tl_d_o.d_ready = tl_h_i[h].d_ready.
  - All other hosts see d_valid=0.
  - A D handshake pops the head.
- FIFO empty with tl_d_i.d_valid=1 (spurious response): d_ready=1 and the beat is dropped. No host sees it.
- Simultaneous push and pop in one cycle: count is unchanged. At full, a pop in the same cycle does not permit a push (full is evaluated from registered count).
- Count width is clog2(MAX_OUT)+1. Read and write pointers wrap modulo MAX_OUT.
- busy_o = (count != 0).
- Reset asserted mid-transaction: state clears immediately and any in-flight responses are lost. The system resets the device in the same domain.
- a_source and a_opcode are passed unmodified. In-order device responses are a system requirement.

Optional Feature:
Macro TLUL_ARB_PRIO_EN.
- Defined: host 0 has fixed highest priority and wins any cycle it requests. The remaining hosts are served round-robin among themselves.
- Not defined: pure round-robin across all M hosts, as described above.

Decomposition:
- Shared package tl_main_pkg: the arbiter-state enum (ARB_IDLE, ARB_GRANT) and the localparam for grant index width (clog2 of max M).
- TL types come from tlul_pkg.
- One sub-module, tlul_arb_idx_fifo: a synchronous FIFO of grant indices with push, pop, full, empty and count, parameterised by width and depth.
- The round-robin pick function stays inline.

Test Plan:
1. M=3, hosts 0,1,2 all assert a_valid every cycle and the device has a_ready=1 → grants are 0,1,2,0,1,2 on consecutive cycles. Each D response (in order, one cycle later) reaches the matching host.
2. Host 1 a_valid=1 and device a_ready=0 for 5 cycles, while host 0 raises a_valid in cycle 2 → tl_d_o carries host 1's address for all 5 cycles. Host 0 is granted in the cycle after host 1's handshake.
3. MAX_OUT=4 and device d_valid held 0: 4 A handshakes complete → count=4 and a_ready=0 to all hosts. One D handshake → exactly one new grant the next cycle.
4. FIFO empty and device asserts d_valid=1 → d_ready=1 and no host d_valid. busy_o stays 0.
5. rst_i pulsed high mid-transfer with count=2 → all valid outputs 0 and busy_o=0 asynchronously. After release, host 0 is granted first.
6. TLUL_ARB_PRIO_EN defined, hosts 0 and 2 requesting continuously → host 0 always granted and host 2 starves. With host 0 idle, hosts 1 and 2 alternate.
